// File: rtl/csa_serial_pkg.sv
// Shared types and constants for the digit-serial carry-select adder.
// The optional subtract mode is enabled by defining CSA_SERIAL_SUB_EN.

package csa_serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DIGIT_W = 2;

   // Digit counter width: enough to index every digit, never narrower than one bit.
   function automatic int cnt_width(input int ndig);
      int w;
      w = $clog2(ndig);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/csa_digit2.sv
// Two-bit carry-select slice: bit 0 ripples, bit 1 is precomputed for both
// carry-in values and chosen by the bit-0 carry.

module csa_digit2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] sum,
   output logic       cout,
   output logic       c0
);

   logic s1_c0;
   logic s1_c1;
   logic co_c0;
   logic co_c1;

   // Ripple bit 0, build both bit-1 candidates, then select with the bit-0 carry.
   always_comb begin
      sum[0] = a[0] ^ b[0] ^ cin;
      c0     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
      s1_c0  = a[1] ^ b[1];
      co_c0  = a[1] & b[1];
      s1_c1  = ~(a[1] ^ b[1]);
      co_c1  = a[1] | b[1];
      sum[1] = c0 ? s1_c1 : s1_c0;
      cout   = c0 ? co_c1 : co_c0;
   end

endmodule

// File: rtl/csa_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 2-bit carry-select digit per cycle,
// least-significant digit first, with the carry held in a register between
// digits. Defining CSA_SERIAL_SUB_EN adds a 'sub' input that turns the
// operation into a - b.

import csa_serial_pkg::*;

module csa_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CSA_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT_W;
   localparam int CNT_W = cnt_width(NDIG);
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0]   counter;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic [WIDTH-1:0]   sum_ins;
   logic               cout_q;
   logic               ovf_q;
   logic [DIGIT_W-1:0] dig_a;
   logic [DIGIT_W-1:0] dig_b;
   logic [DIGIT_W-1:0] dig_sum;
   logic               dig_cout;
   logic               dig_c0;
   logic               accept;
   logic               last_dig;

   assign accept   = (state == IDLE) && in_valid;
   assign last_dig = (counter == LAST_DIG);

   csa_digit2 u_digit (
      .a    (dig_a),
      .b    (dig_b),
      .cin  (carry_q),
      .sum  (dig_sum),
      .cout (dig_cout),
      .c0   (dig_c0)
   );

   // Pick the current digit's operand bits and splice its sum into the result word.
   always_comb begin
      dig_a   = '0;
      dig_b   = '0;
      sum_ins = sum_q;
      for (int d = 0; d < NDIG; d++) begin
         if (counter == CNT_W'(d)) begin
            dig_a = a_q[d*DIGIT_W +: DIGIT_W];
            dig_b = b_q[d*DIGIT_W +: DIGIT_W];
            sum_ins[d*DIGIT_W +: DIGIT_W] = dig_sum;
         end
      end
   end

   // State register; reset discards any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accept in IDLE, step digits in RUN, wait for the consumer in DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = RUN;
         RUN:  if (last_dig) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs depend only on the current state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath: capture operands on accept, then one digit per RUN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else if (accept) begin
         a_q     <= a;
`ifdef CSA_SERIAL_SUB_EN
         b_q     <= sub ? ~b : b;
         carry_q <= sub ? 1'b1 : cin;
`else
         b_q     <= b;
         carry_q <= cin;
`endif
         sum_q   <= '0;
         counter <= '0;
      end else if (state == RUN) begin
         sum_q   <= sum_ins;
         carry_q <= dig_cout;
         if (last_dig) begin
            cout_q <= dig_cout;
            ovf_q  <= dig_c0 ^ dig_cout;
         end else begin
            counter <= counter + 1'b1;
         end
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_csa_serial_adder.sv
// Self-checking bench for csa_serial_adder (WIDTH=8): directed cases plus
// randomized transactions against an arithmetic reference model.
// Subtract cases run only when CSA_SERIAL_SUB_EN is defined.

module tb_csa_serial_adder;

   localparam int WIDTH = 8;
   localparam int NDIG  = WIDTH / 2;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   int checks;
   int errors;

   csa_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CSA_SERIAL_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, result packed as {overflow, cout, sum}.
   function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic ci,
                                                 input logic sb);
      int ux, uy, sx, sy, ures, sres;
      logic c, v;
      logic [WIDTH-1:0] s;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (sb) begin
         ures = ux - uy;
         c    = (ux >= uy);
         sres = sx - sy;
      end else begin
         ures = ux + uy + int'(ci);
         c    = (ures >= (1 << WIDTH));
         sres = sx + sy + int'(ci);
      end
      s = ures[WIDTH-1:0];
      v = (sres > 127) || (sres < -128);
      return {v, c, s};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction: accept, check latency, check result, hold under backpressure, release.
   task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic ci, input logic sb, input int hold);
      logic [WIDTH+1:0] exp;
      exp       = refModel(x, y, ci, sb);
      a         = x;
      b         = y;
      cin       = ci;
      sub       = sb;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      checkOutput("in_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      checkOutput("in_ready_run", in_ready, 0);
      for (int k = 1; k < NDIG; k++) begin
         @(posedge clk); #1;
         checkOutput("out_valid_early", out_valid, 0);
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
      end
      @(posedge clk); #1;
      checkOutput("out_valid_rise", out_valid, 1);
      checkOutput("in_ready_done", in_ready, 0);
      checkOutput("sum", sum, 32'(exp[WIDTH-1:0]));
      checkOutput("cout", cout, 32'(exp[WIDTH]));
      checkOutput("overflow", overflow, 32'(exp[WIDTH+1]));
      in_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", out_valid, 1);
         checkOutput("hold_sum", sum, 32'(exp[WIDTH-1:0]));
         checkOutput("hold_cout", cout, 32'(exp[WIDTH]));
         checkOutput("hold_overflow", overflow, 32'(exp[WIDTH+1]));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("out_valid_drop", out_valid, 0);
      checkOutput("in_ready_back", in_ready, 1);
   endtask

   initial begin
      logic sb;
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      $display("[TB] starting csa_serial_adder bench");

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_sum", sum, 0);
      checkOutput("rst_cout", cout, 0);
      checkOutput("rst_overflow", overflow, 0);

      applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 0);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1);
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 3);

      a        = 8'h55;
      b        = 8'h22;
      cin      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_in_ready", in_ready, 1);
      checkOutput("midrst_sum", sum, 0);
      checkOutput("midrst_cout", cout, 0);
      repeat (NDIG) @(posedge clk);
      #1;
      checkOutput("midrst_no_result", out_valid, 0);

      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 0);
      applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, 0);
      applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 0);
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 0);

`ifdef CSA_SERIAL_SUB_EN
      applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, 0);
      applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 1);
      applyStimulus(8'h7F, 8'hFF, 1'b1, 1'b1, 0);
`endif

      for (int n = 0; n < 40; n++) begin
`ifdef CSA_SERIAL_SUB_EN
         sb = 1'($urandom);
`else
         sb = 1'b0;
`endif
         applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sb,
                       int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csa_serial_adder.md
Name: csa_serial_adder

Overview:
Digit-serial WIDTH-bit adder for the ALU datapath.
- Drives one 2-bit carry-select slice per cycle, least-significant digit first, and feeds each slice carry-out back as the next digit's carry-in.
- Sits in front of the ALU result mux. Accepts operands through a valid/ready handshake and returns sum, carry and signed overflow through a valid/ready handshake.
- Trades latency for area versus a full-width carry-select adder.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and at least 2.
- NDIG, WIDTH/2: number of 2-bit digits. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
Reset
- One clock, one synchronous active-high reset, named clk and reset.
- reset=1 at an edge forces: state=IDLE, digit counter=0, carry register=0, sum=0, cout=0, overflow=0, out_valid=0.
- in_ready=1 from the first edge after reset is released.
- Reset wins over every other event, including in the middle of RUN or DONE. Any partial result is discarded and no out_valid is produced for it.

FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE); out_valid = (state==DONE); both decoded from state only.
- IDLE: on in_valid at edge T, latch a and b into operand registers and cin into the carry register. Clear sum, set counter=0, go to RUN.
- RUN, digit k = counter:
  - Slice input: a[2k+1:2k], b[2k+1:2k] and the carry register.
  - At each edge, write the slice sum into sum[2k+1:2k] and load the slice carry-out into the carry register.
  - If k==NDIG-1: set cout = slice carry-out, set overflow = (slice internal carry out of its bit 0) XOR (slice carry-out), go to DONE.
  - Otherwise counter increments.
- DONE: sum, cout and overflow are held stable while out_ready=0. On out_ready=1 go to IDLE; in_valid is ignored in DONE.

Timing and throughput
- Accept at edge T gives out_valid=1 from edge T+NDIG.
- Earliest next accept is one cycle after the out handshake, so throughput is one result per NDIG+2 cycles.
- WIDTH=2 gives exactly one RUN cycle.

Arithmetic
- Modulo 2^WIDTH. Carry propagates only through the registered carry; there is no combinational path from cin to cout.
- Inputs a and b are sampled only at the accept edge; later changes do not affect the result.

Optional Feature:
Macro CSA_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at the accept edge.
  - sub=1: operand register loads ~b, the carry register loads 1 and cin is ignored, giving a-b. cout=1 means no borrow; overflow is the signed subtraction overflow.
  - sub=0: identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Package csa_serial_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - constant DIGIT_W=2
  - function computing the counter width, clog2(NDIG) with a minimum of 1
- Sub-module csa_digit2 is the 2-bit carry-select slice:
  - bit 0 ripple; bit 1 computed for carry-in 0 and 1, selected by the bit-0 carry
  - outputs sum[1:0], carry-out and bit-0 carry
  - instantiated once, combinational

Test Plan (WIDTH=8):
- a=0x7F, b=0x01, cin=0 accepted at edge T -> out_valid rises at edge T+4; sum=0x80, cout=0, overflow=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, overflow=0; in_ready=0 throughout RUN and DONE.
- Backpressure: complete 0xFF+0x01, hold out_ready=0 for 3 cycles -> sum=0x00, cout=1 stable every cycle; out_valid drops at the first edge after out_ready=1.
- Reset asserted at RUN digit 2 -> next cycle IDLE, out_valid=0, in_ready=1; then 0x12+0x34 -> sum=0x46, cout=0.
- Change a/b during RUN after accepting 0x0F+0x01 -> result still 0x10.
- CSA_SERIAL_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, overflow=0.
- CSA_SERIAL_SUB_EN defined: a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
